inst_rom_loader: RTL and testbench

- Instruction-memory responder for the pipeline's fetch port.
  - The core drives rom_ce/rom_addr.
  - This block returns rom_data combinationally in the same cycle, so the IF/ID register captures it at the next edge.
- Adds a byte-serial load port with a valid/ready handshake. A host uses it to fill the memory at run time.
- Drives a hold signal that keeps the core in reset while a load is in progress.

---
 rtl/inst_rom_loader.sv | 202 ++++++++++++++++++++
 tb/tb_inst_rom_loader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// inst_rom_loader
//   Instruction memory for the fetch port, plus a byte-serial load port
//   that lets a host refill the memory at run time.
//
//   Fetch side (combinational, zero latency):
//     rom_ce_i, rom_addr_i -> rom_data_o
//       - rom_data_o is 0 when rom_ce_i is low.
//       - It is FILL_WORD while a load is in progress, or when the address
//         is outside the memory.
//       - The bottom two address bits are ignored.
//   Load side (valid/ready handshake):
//     ld_start_i        opens a session from IDLE.
//     ld_valid_i/ld_byte_i/ld_last_i
//                       carry the byte stream, little-endian within a word.
//     ld_ready_o        is high while receiving bytes.
//     ld_busy_o         is high from session start through the drain cycle.
//     ld_words_o        counts words committed in the current session.
//     ld_err_o          is sticky. It is set by a partial last word or by
//                       an overflow.
//     ld_csum_o         is the running sum of committed words.
//     cpu_hold_o        mirrors ld_busy_o and keeps the core in reset.
//   Reset: rst, asynchronous, active-low. Memory contents survive reset.
//   Optional feature: define ROM_LOAD_CHECKSUM_EN to enable the checksum
//   accumulator. When it is not defined, ld_csum_o is tied to 0.
module inst_rom_loader #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] FILL_WORD  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  ld_busy_o,
  output logic [DEPTH_LOG2:0]   ld_words_o,
  output logic                  ld_err_o,
  output logic [31:0]           ld_csum_o,
  output logic                  cpu_hold_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t                state_reg;
  logic                  ready_reg;
  logic                  busy_reg;
  logic                  hold_reg;
  logic                  err_reg;
  logic [1:0]            cnt_reg;
  logic [23:0]           asm_reg;   // lower three byte lanes of the word in progress
  // The write pointer doubles as the committed-word count. Both advance
  // together and neither moves on an overflow.
  logic [DEPTH_LOG2:0]   wptr_reg;

  logic [31:0] mem [DEPTH];

  logic        xfer;
  logic        word_done;
  logic        mem_full;
  logic        mem_we;
  logic [31:0] asm_word;
  logic        addr_hi_set;
  logic        unused_addr_bits;

  assign xfer      = ready_reg & ld_valid_i;
  assign word_done = xfer & ((cnt_reg == 2'd3) | ld_last_i);
  // wptr only reaches DEPTH and stops there, so its top bit marks "full".
  assign mem_full  = wptr_reg[DEPTH_LOG2];
  assign mem_we    = word_done & ~mem_full;

  // The incoming byte is merged into its lane. asm_reg is cleared after
  // every commit, so lanes above the current byte are already zero. A
  // short last word therefore comes out zero-padded without extra logic.
  always_comb begin
    asm_word = {8'h00, asm_reg};
    case (cnt_reg)
      2'd0:    asm_word[7:0]   = ld_byte_i;
      2'd1:    asm_word[15:8]  = ld_byte_i;
      2'd2:    asm_word[23:16] = ld_byte_i;
      default: asm_word[31:24] = ld_byte_i;
    endcase
  end

  // Memory write port. This block has no reset, so reset leaves the
  // contents intact.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr_reg[DEPTH_LOG2-1:0]] <= asm_word;
    end
  end

  // Fetch path.
  assign addr_hi_set      = |rom_addr_i[31:DEPTH_LOG2+2];
  assign unused_addr_bits = ^rom_addr_i[1:0];

  always_comb begin
    rom_data_o = 32'h0000_0000;
    if (rom_ce_i) begin
      if (busy_reg || addr_hi_set) begin
        rom_data_o = FILL_WORD;
      end else begin
        rom_data_o = mem[rom_addr_i[DEPTH_LOG2+1:2]];
      end
    end
  end

  // Load FSM. All handshake and status outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      hold_reg  <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= 2'd0;
      asm_reg   <= 24'h0;
      wptr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ld_start_i) begin
            state_reg <= RECV;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b1;
            hold_reg  <= 1'b1;
            err_reg   <= 1'b0;
            cnt_reg   <= 2'd0;
            asm_reg   <= 24'h0;
            wptr_reg  <= '0;
          end
        end
        RECV: begin
          if (xfer) begin
            if (word_done) begin
              cnt_reg <= 2'd0;
              asm_reg <= 24'h0;
              if (!mem_full) begin
                wptr_reg <= wptr_reg + (DEPTH_LOG2+1)'(1);
              end else begin
                err_reg <= 1'b1;
              end
              // A last byte that arrives before lane 3 means a short word.
              if (ld_last_i && (cnt_reg != 2'd3)) begin
                err_reg <= 1'b1;
              end
            end else begin
              cnt_reg <= cnt_reg + 2'd1;
              asm_reg <= asm_word[23:0];
            end
            if (ld_last_i) begin
              state_reg <= DRAIN;
              ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          hold_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          hold_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [31:0] csum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_reg <= 32'h0;
    end else if ((state_reg == IDLE) && ld_start_i) begin
      csum_reg <= 32'h0;
    end else if (mem_we) begin
      // Dropped overflow words never assert mem_we, so they are excluded.
      csum_reg <= csum_reg + asm_word;
    end
  end

  assign ld_csum_o = csum_reg;
`else
  assign ld_csum_o = 32'h0;
`endif

  assign ld_ready_o = ready_reg;
  assign ld_busy_o  = busy_reg;
  assign cpu_hold_o = hold_reg;
  assign ld_err_o   = err_reg;
  assign ld_words_o = wptr_reg;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Testbench for inst_rom_loader.
//   - Builds a 4-word instance so that overflow is easy to reach.
//   - Drives directed load sessions and randomized load sessions.
//   - Stimulus pushes expected results into queues. A monitor process pops
//     and compares them when the DUT presents the matching output:
//       * a fetch (rom_ce_i high),
//       * a status strobe,
//       * or the falling edge of ld_busy_o at the end of a session.
//   - The reference model converts each session's byte list into words
//     with plain arithmetic.
module tb_inst_rom_loader;
  localparam int          DL    = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] FILL  = 32'h0000_0013;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          words;
    bit          err;
    logic [31:0] csum;
    bit          by_reset;
  } sess_t;

  typedef struct {
    bit          ready;
    bit          busy;
    bit          hold;
    bit          chk_cnt;
    int          words;
    bit          err;
    logic [31:0] csum;
  } st_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce_i = 1'b0;
  logic [31:0]   rom_addr_i = 32'h0;
  logic [31:0]   rom_data_o;
  logic          ld_start_i = 1'b0;
  logic          ld_valid_i = 1'b0;
  logic [7:0]    ld_byte_i = 8'h00;
  logic          ld_last_i = 1'b0;
  logic          ld_ready_o;
  logic          ld_busy_o;
  logic [DL:0]   ld_words_o;
  logic          ld_err_o;
  logic [31:0]   ld_csum_o;
  logic          cpu_hold_o;

  inst_rom_loader #(.DEPTH_LOG2(DL), .FILL_WORD(FILL)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .ld_start_i (ld_start_i),
    .ld_valid_i (ld_valid_i),
    .ld_byte_i  (ld_byte_i),
    .ld_last_i  (ld_last_i),
    .ld_ready_o (ld_ready_o),
    .ld_busy_o  (ld_busy_o),
    .ld_words_o (ld_words_o),
    .ld_err_o   (ld_err_o),
    .ld_csum_o  (ld_csum_o),
    .cpu_hold_o (cpu_hold_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_q[$];
  sess_t       sess_q[$];
  st_t         st_q[$];
  bit          st_strobe = 1'b0;

  logic [31:0] mref [DEPTH];
  bit          mref_ok [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit prev_busy = 1'b0;
  int last_cyc  = -100;

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    sess_t       s;
    st_t         st;
    if (ld_valid_i && ld_ready_o && ld_last_i) last_cyc = cyc;
    if (rom_ce_i) begin
      if (rd_q.size() == 0) chk("unexpected_fetch", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("rom_data", rom_data_o, e);
      end
    end else begin
      chk("rom_data_ce0", rom_data_o, 0);
    end
    if (st_strobe) begin
      if (st_q.size() == 0) chk("status_q_empty", 1, 0);
      else begin
        st = st_q.pop_front();
        chk("ready", ld_ready_o, st.ready);
        chk("busy", ld_busy_o, st.busy);
        chk("cpu_hold", cpu_hold_o, st.hold);
        if (st.chk_cnt) begin
          chk("status_words", ld_words_o, st.words);
          chk("status_err", ld_err_o, st.err);
          chk("status_csum", ld_csum_o, st.csum);
        end
      end
    end
    if (prev_busy && !ld_busy_o) begin
      if (sess_q.size() == 0) chk("unexpected_session_end", 1, 0);
      else begin
        s = sess_q.pop_front();
        chk("sess_words", ld_words_o, s.words);
        chk("sess_err", ld_err_o, s.err);
        chk("sess_csum", ld_csum_o, s.csum);
        if (!s.by_reset) chk("busy_fall_latency", cyc - last_cyc, 2);
      end
    end
    prev_busy = ld_busy_o;
  end

  // ---------------- reference model ----------------
  // Bytes are grouped four per word, little-endian, and a short tail is
  // zero-padded. Only the first DEPTH words are stored. The error flag
  // is set by a short tail or by any word beyond DEPTH. If the session
  // is cut by reset, only complete words are kept.
  task automatic model_session(input bq_t b, input bit cut_by_reset, output sess_t s);
    int n, nw, committed;
    logic [31:0] w, sum;
    n  = b.size();
    nw = cut_by_reset ? n / 4 : (n + 3) / 4;
    committed = (nw > DEPTH) ? DEPTH : nw;
    sum = 32'h0;
    for (int wi = 0; wi < committed; wi++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        if (wi * 4 + k < n) w[8*k +: 8] = b[wi * 4 + k];
      mref[wi]    = w;
      mref_ok[wi] = 1'b1;
      sum = sum + w;
    end
    s.by_reset = cut_by_reset;
    if (cut_by_reset) begin
      s.words = 0; s.err = 1'b0; s.csum = 32'h0;
    end else begin
      s.words = committed;
      s.err   = ((n % 4) != 0) || (nw > DEPTH);
`ifdef ROM_LOAD_CHECKSUM_EN
      s.csum  = sum;
`else
      s.csum  = 32'h0;
`endif
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    ld_start_i = 1'b1; tick(); ld_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    bit got;
    got = 1'b0;
    ld_valid_i = 1'b1; ld_byte_i = b; ld_last_i = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ld_ready_o) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (!ld_busy_o) idle = 1'b1;
    end
    if (!idle) chk("idle_timeout", 0, 1);
    tick();
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] e);
    rom_ce_i = 1'b1; rom_addr_i = a; rd_q.push_back(e);
    tick();
    rom_ce_i = 1'b0;
  endtask

  task automatic status(input st_t st);
    st_q.push_back(st);
    st_strobe = 1'b1;
    tick();
    st_strobe = 1'b0;
  endtask

  task automatic run_session(input bq_t b, input int gap_max, input int extra_start_at,
                             input int fetch_at, input bit hold_after);
    sess_t s;
    st_t   st;
    model_session(b, 1'b0, s);
    sess_q.push_back(s);
    pulse_start();
    for (int i = 0; i < b.size(); i++) begin
      if (i == extra_start_at) pulse_start();
      if (i == fetch_at) begin
        st = '{ready: 1, busy: 1, hold: 1, chk_cnt: 0, words: 0, err: 0, csum: 0};
        st_q.push_back(st);
        st_strobe = 1'b1;
        fetch($urandom_range(0, 15), FILL);
        st_strobe = 1'b0;
      end
      repeat ($urandom_range(0, gap_max)) tick();
      send_byte(b[i], i == b.size() - 1);
    end
    if (hold_after) begin
      ld_valid_i = 1'b1; ld_byte_i = 8'hEE; ld_last_i = 1'b0;
      repeat (4) tick();
      ld_valid_i = 1'b0;
    end
    wait_idle();
  endtask

  task automatic readback();
    for (int a = 0; a < DEPTH; a++)
      if (mref_ok[a]) fetch(a * 4 + $urandom_range(0, 3), mref[a]);
    fetch($urandom | (32'h1 << $urandom_range(4, 31)), FILL);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    bq_t   b;
    sess_t s;
    st_t   st0;
    st0 = '{ready: 0, busy: 0, hold: 0, chk_cnt: 1, words: 0, err: 0, csum: 0};
    for (int a = 0; a < DEPTH; a++) mref_ok[a] = 1'b0;

    #2 rst = 1'b0;
    tick();
    rom_addr_i = 32'hFFFF_FFFF;
    tick();
    status(st0);
    rst = 1'b1;
    tick();
    status(st0);

    // Basic two-word load, then read back.
    b = '{8'h01, 8'h00, 8'h02, 8'h34, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_session(b, 0, -1, -1, 1'b0);
    fetch(32'h0, 32'h3402_0001);
    fetch(32'h4, 32'hDDCC_BBAA);
    fetch(32'h5, 32'hDDCC_BBAA);

    // Partial last word.
    b = '{8'h11, 8'h22};
    run_session(b, 0, -1, -1, 1'b0);
    fetch(32'h0, 32'h0000_2211);
    readback();

    // Overflow: 20 bytes into a 4-word memory.
    b = {};
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    run_session(b, 1, -1, -1, 1'b0);
    readback();
    fetch(32'h10, FILL);

    // Backpressure, fetch while loading, and a second start mid-session.
    b = {};
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    run_session(b, 1, 3, 5, 1'b1);
    readback();

    // Reset in the middle of a session, after 6 bytes.
    b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    model_session(b, 1'b1, s);
    sess_q.push_back(s);
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(b[i], 1'b0);
    tick();
    rst = 1'b0;
    tick();
    status(st0);
    rst = 1'b1;
    tick();
    status(st0);
    readback();

    // Randomized sessions.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(1, 22);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      run_session(b, 2,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                  1'($urandom_range(0, 1)));
      readback();
    end

    repeat (3) tick();
    chk("fetch_queue_drained", rd_q.size(), 0);
    chk("session_queue_drained", sess_q.size(), 0);
    chk("status_queue_drained", st_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
